// File: rtl/dogx_frame_serializer.sv
// dogx_frame_serializer: boxcar decimator, one-entry holding buffer and
// three-wire MSB-first frame shifter with sticky overrun.
//
// Ports:
//   CLK_24M      system clock
//   reset        asynchronous, active-low reset
//   enable_3M    one-cycle sample strobe
//   sample_in    signed 11-bit converter sample
//   alpha_in     channel-select flag for sample_in
//   serial_en    link enable; low flushes decimator and holding buffer
//   overrun_clr  synchronous clear of overrun
//   sclk         serial bit clock
//   sdata        serial data, MSB first
//   fsync        high during bit 15 of each frame
//   overrun      sticky overrun flag
module dogx_frame_serializer #(
   parameter int DECIM  = 8,
   parameter int CLKDIV = 2
) (
   input  logic        CLK_24M,
   input  logic        reset,
   input  logic        enable_3M,
   input  logic [10:0] sample_in,
   input  logic        alpha_in,
   input  logic        serial_en,
   input  logic        overrun_clr,
   output logic        sclk,
   output logic        sdata,
   output logic        fsync,
   output logic        overrun
);

   localparam int CW = $clog2(DECIM);
   localparam int DW = $clog2(CLKDIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLKDIV / 2);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic signed [14:0] acc;
   logic signed [14:0] samp_ext;
   logic signed [14:0] sum;
   logic [CW-1:0]     cnt;
   logic              alpha_or;
   logic [15:0]       hold_data;
   logic              hold_valid;
   logic              hold_ok;
   logic [15:0]       shift_reg;
   logic [3:0]        bit_idx;
   logic [DW-1:0]     div_cnt;
   logic              frame_vld;
   logic              bit_end;
   logic              last_bit;
   logic              load;
   logic              drop;
   logic              overrun_q;

   assign samp_ext  = {{4{sample_in[10]}}, sample_in};
   assign sum       = acc + samp_ext;
   assign frame_vld = enable_3M & serial_en
                    & (cnt == CNT_LAST);
   // A flushed buffer must never reach the shifter.
   assign hold_ok   = hold_valid & serial_en;
   assign bit_end   = (state == SHIFT)
                    & (div_cnt == DIV_LAST);
   assign last_bit  = bit_end & (bit_idx == 4'd0);
   assign drop      = frame_vld & hold_valid & ~load;

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            if (hold_ok) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               if (hold_ok) begin
                  load = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decode registered state, so reset forces them low at once.
   assign sclk    = (state == SHIFT) & (div_cnt >= DIV_HALF);
   assign sdata   = (state == SHIFT) & shift_reg[bit_idx];
   assign fsync   = (state == SHIFT) & (bit_idx == 4'd15);
   assign overrun = overrun_q;

   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         cnt      <= '0;
         alpha_or <= 1'b0;
      end else if (!serial_en) begin
         acc      <= '0;
         cnt      <= '0;
         alpha_or <= 1'b0;
      end else if (enable_3M) begin
         if (cnt == CNT_LAST) begin
            acc      <= '0;
            cnt      <= '0;
            alpha_or <= 1'b0;
         end else begin
            acc      <= sum;
            cnt      <= cnt + 1'b1;
            alpha_or <= alpha_or | alpha_in;
         end
      end
   end

   // A frame arriving while the shifter loads takes the freed slot.
   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
      end else if (!serial_en) begin
         hold_valid <= 1'b0;
      end else if (frame_vld && (!hold_valid || load)) begin
         hold_data  <= {alpha_or | alpha_in, sum};
         hold_valid <= 1'b1;
      end else if (load) begin
         hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         div_cnt   <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            shift_reg <= hold_data;
            bit_idx   <= 4'd15;
            div_cnt   <= '0;
         end else if (state == SHIFT) begin
            if (bit_end) begin
               div_cnt <= '0;
               bit_idx <= bit_idx - 1'b1;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
      end
   end

   // Set takes priority over a simultaneous clear.
   always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= drop | (overrun_q & ~overrun_clr);
      end
   end

endmodule
